td4_sequencer: RTL and testbench

Instruction sequencer for the TD4 4-bit CPU: it fetches 8-bit instructions from program ROM, decodes them, and drives the data selector's `SELECT` code and immediate. It also issues register load strobes and owns the program counter and carry flag. It sits between program ROM and the selector/adder/register datapath, one instruction every two or more cycles.

---
 rtl/td4_pkg.sv | 26 ++
 rtl/td4_decoder.sv | 39 +++
 rtl/td4_sequencer.sv | 94 +++++++++
 tb/tb_td4_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/td4_pkg.sv
// td4_pkg: opcodes, selector codes and FSM state type shared by the TD4 sequencer
package td4_pkg;
    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_A   = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_B   = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_IM  = 4'b1011;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

    localparam logic [1:0] SEL_A  = 2'b00;
    localparam logic [1:0] SEL_B  = 2'b01;
    localparam logic [1:0] SEL_IN = 2'b10;
    localparam logic [1:0] SEL_IM = 2'b11;

`ifdef TD4_HALT_EN
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_HALT} state_t;
`else
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC} state_t;
`endif
endpackage

// File: rtl/td4_decoder.sv
// td4_decoder: combinational instruction decode, IR -> selector code, immediate, strobes, jump flags
module td4_decoder
    import td4_pkg::*;
(
    input  logic [7:0] ir,
    output logic [1:0] sel,
    output logic [3:0] im,
    output logic       load_a,
    output logic       load_b,
    output logic       load_out,
    output logic       jmp,
    output logic       jnc
);
    // Opcode table; register-to-register moves force the immediate to zero
    always_comb begin
        sel      = SEL_A;
        im       = ir[3:0];
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_out = 1'b0;
        jmp      = 1'b0;
        jnc      = 1'b0;
        case (ir[7:4])
            OP_ADD_A:   load_a = 1'b1;
            OP_ADD_B:   begin sel = SEL_B;  load_b = 1'b1; end
            OP_MOV_A:   begin sel = SEL_IM; load_a = 1'b1; end
            OP_MOV_B:   begin sel = SEL_IM; load_b = 1'b1; end
            OP_MOV_A_B: begin sel = SEL_B;  im = 4'h0; load_a = 1'b1; end
            OP_MOV_B_A: begin im = 4'h0; load_b = 1'b1; end
            OP_IN_A:    begin sel = SEL_IN; load_a = 1'b1; end
            OP_IN_B:    begin sel = SEL_IN; load_b = 1'b1; end
            OP_OUT_B:   begin sel = SEL_B;  im = 4'h0; load_out = 1'b1; end
            OP_OUT_IM:  begin sel = SEL_IM; load_out = 1'b1; end
            OP_JMP:     begin sel = SEL_IM; jmp = 1'b1; end
            OP_JNC:     begin sel = SEL_IM; jnc = 1'b1; end
            default:    im = 4'h0;
        endcase
    end
endmodule

// File: rtl/td4_sequencer.sv
// td4_sequencer: TD4 fetch/execute sequencer owning PC, IR and carry; TD4_HALT_EN adds a halt-on-jump-to-self state
module td4_sequencer
    import td4_pkg::*;
#(
    parameter logic [3:0] PC_RESET = 4'h0
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       RUN,
    output logic [3:0] ROM_ADDR,
    input  logic [7:0] ROM_DATA,
    input  logic       ROM_VALID,
    output logic [1:0] SELECT,
    output logic [3:0] IM,
    input  logic       ALU_CARRY,
    output logic       LOAD_A,
    output logic       LOAD_B,
    output logic       LOAD_OUT,
    output logic       CARRY_FLAG,
    output logic       HALTED
);
    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic       carry_q, carry_d;
    logic [1:0] d_sel;
    logic [3:0] d_im;
    logic       d_la, d_lb, d_lo, d_jmp, d_jnc;
    logic       exec, taken;

    td4_decoder u_dec (
        .ir       (ir_q),
        .sel      (d_sel),
        .im       (d_im),
        .load_a   (d_la),
        .load_b   (d_lb),
        .load_out (d_lo),
        .jmp      (d_jmp),
        .jnc      (d_jnc)
    );

    assign exec       = (state_q == ST_EXEC);
    assign taken      = d_jmp | (d_jnc & ~carry_q);
    assign ROM_ADDR   = pc_q;
    assign SELECT     = exec ? d_sel : SEL_A;
    assign IM         = exec ? d_im : 4'h0;
    assign LOAD_A     = exec & d_la;
    assign LOAD_B     = exec & d_lb;
    assign LOAD_OUT   = exec & d_lo;
    assign CARRY_FLAG = carry_q;
`ifdef TD4_HALT_EN
    assign HALTED     = (state_q == ST_HALT);
`else
    assign HALTED     = 1'b0;
`endif

    // Next-state: capture IR in FETCH, retire the instruction (PC, carry) at the end of EXEC
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        carry_d = carry_q;
        case (state_q)
            ST_FETCH: if (RUN && ROM_VALID) begin
                ir_d    = ROM_DATA;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                carry_d = ALU_CARRY;
                pc_d    = taken ? d_im : pc_q + 4'd1;
                state_d = ST_FETCH;
`ifdef TD4_HALT_EN
                if (taken && d_im == pc_q) state_d = ST_HALT;
`endif
            end
            default: ;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            carry_q <= carry_d;
        end
    end
endmodule

// File: tb/tb_td4_sequencer.sv
// tb_td4_sequencer: directed-vector self-checking bench for td4_sequencer (honours TD4_HALT_EN)
module tb_td4_sequencer;
    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       RUN;
    logic [3:0] ROM_ADDR;
    logic [7:0] ROM_DATA;
    logic       ROM_VALID;
    logic [1:0] SELECT;
    logic [3:0] IM;
    logic       ALU_CARRY;
    logic       LOAD_A, LOAD_B, LOAD_OUT;
    logic       CARRY_FLAG;
    logic       HALTED;
    logic [7:0] rom [16];
    int         n_chk = 0;
    int         n_pass = 0;

    td4_sequencer #(.PC_RESET(4'h0)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .RUN        (RUN),
        .ROM_ADDR   (ROM_ADDR),
        .ROM_DATA   (ROM_DATA),
        .ROM_VALID  (ROM_VALID),
        .SELECT     (SELECT),
        .IM         (IM),
        .ALU_CARRY  (ALU_CARRY),
        .LOAD_A     (LOAD_A),
        .LOAD_B     (LOAD_B),
        .LOAD_OUT   (LOAD_OUT),
        .CARRY_FLAG (CARRY_FLAG),
        .HALTED     (HALTED)
    );

    always #5 CLK = ~CLK;

    assign ROM_DATA = rom[ROM_ADDR];

    // Control bundle: {SELECT, IM, LOAD_A, LOAD_B, LOAD_OUT}
    wire [8:0] ctl = {SELECT, IM, LOAD_A, LOAD_B, LOAD_OUT};

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0]  = 8'h35;
        rom[1]  = 8'h0F;
        rom[2]  = 8'hE8;
        rom[3]  = 8'hE8;
        rom[8]  = 8'hFF;
        rom[15] = 8'h40;
        RESET_N   = 1'b0;
        RUN       = 1'b1;
        ROM_VALID = 1'b1;
        ALU_CARRY = 1'b0;
        #12;
        check("rst_addr", 16'(ROM_ADDR), 16'h0);
        check("rst_ctl", 16'(ctl), 16'h0);
        check("rst_carry", 16'(CARRY_FLAG), 16'h0);
        check("rst_halted", 16'(HALTED), 16'h0);
        RESET_N = 1'b1;
        step();
        check("mov_a5_ctl", 16'(ctl), 16'({2'b11, 4'h5, 3'b100}));
        step();
        check("fetch1_addr", 16'(ROM_ADDR), 16'h1);
        check("fetch1_ctl", 16'(ctl), 16'h0);
        step();
        check("add_af_ctl", 16'(ctl), 16'({2'b00, 4'hF, 3'b100}));
        ALU_CARRY = 1'b1;
        step();
        check("carry_set", 16'(CARRY_FLAG), 16'h1);
        check("fetch2_addr", 16'(ROM_ADDR), 16'h2);
        ALU_CARRY = 1'b0;
        step();
        check("jnc_ctl", 16'(ctl), 16'({2'b11, 4'h8, 3'b000}));
        step();
        check("jnc_not_taken", 16'(ROM_ADDR), 16'h3);
        check("carry_clr", 16'(CARRY_FLAG), 16'h0);
        step();
        step();
        check("jnc_taken", 16'(ROM_ADDR), 16'h8);
        step();
        step();
        check("jmp_f", 16'(ROM_ADDR), 16'hF);
        step();
        check("mov_ba_ctl", 16'(ctl), 16'({2'b00, 4'h0, 3'b010}));
        step();
        check("pc_wrap", 16'(ROM_ADDR), 16'h0);
        ROM_VALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_addr", 16'(ROM_ADDR), 16'h0);
            check("stall_ctl", 16'(ctl), 16'h0);
        end
        ROM_VALID = 1'b1;
        ALU_CARRY = 1'b1;
        step();
        check("post_stall_ctl", 16'(ctl), 16'({2'b11, 4'h5, 3'b100}));
        step();
        check("carry_pre_rst", 16'(CARRY_FLAG), 16'h1);
        ALU_CARRY = 1'b0;
        rom[1] = 8'hB7;
        step();
        check("out_im_ctl", 16'(ctl), 16'({2'b11, 4'h7, 3'b001}));
        RESET_N = 1'b0;
        #1;
        check("async_rst_ctl", 16'(ctl), 16'h0);
        check("async_rst_addr", 16'(ROM_ADDR), 16'h0);
        check("async_rst_carry", 16'(CARRY_FLAG), 16'h0);
        rom[0] = 8'hF3;
        rom[3] = 8'hF3;
        #2;
        RESET_N = 1'b1;
        step();
        check("jmp3_ctl", 16'(ctl), 16'({2'b11, 4'h3, 3'b000}));
        step();
        check("jmp3_addr", 16'(ROM_ADDR), 16'h3);
        RUN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("run_low_addr", 16'(ROM_ADDR), 16'h3);
            check("run_low_ctl", 16'(ctl), 16'h0);
        end
        RUN = 1'b1;
        step();
        check("self_jmp_ctl", 16'(ctl), 16'({2'b11, 4'h3, 3'b000}));
`ifdef TD4_HALT_EN
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_flag", 16'(HALTED), 16'h1);
            check("halt_ctl", 16'(ctl), 16'h0);
            check("halt_addr", 16'(ROM_ADDR), 16'h3);
        end
`else
        step();
        check("loop_fetch_ctl", 16'(ctl), 16'h0);
        check("loop_addr", 16'(ROM_ADDR), 16'h3);
        check("loop_halted", 16'(HALTED), 16'h0);
        step();
        check("loop_exec_ctl", 16'(ctl), 16'({2'b11, 4'h3, 3'b000}));
        step();
        check("loop_addr2", 16'(ROM_ADDR), 16'h3);
        check("loop_halted2", 16'(HALTED), 16'h0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
